// File: rtl/vector_shift_pkg.sv
// Shared types and constants for the vector shift sequencer.
package vector_shift_pkg;

    localparam int unsigned VLEN      = 512;
    localparam int unsigned LANE_W    = 128;
    localparam int unsigned NUM_LANES = VLEN / LANE_W;
    localparam int unsigned VL_W      = 10;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b01,
        SRA = 2'b10
    } shift_op_e;

    typedef enum logic [1:0] {
        SEW8  = 2'b00,
        SEW16 = 2'b01,
        SEW32 = 2'b10
    } sew_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_e;

endpackage

// File: rtl/vector_shift_lane_dp.sv
// Combinational 128-bit lane shifter: element-wise vsll/vsrl/vsra at SEW 8/16/32.
module vector_shift_lane_dp
    import vector_shift_pkg::*;
(
    input  logic [LANE_W-1:0] vs2_i,
    input  logic [LANE_W-1:0] vs1_i,
    input  logic [4:0]        rs1_i,
    input  logic              use_scalar_i,
    input  shift_op_e         op_i,
    input  sew_e              sew_i,
    output logic [LANE_W-1:0] res_o
);

    // Only the low log2(SEW) bits of each vs1 element matter.
    logic unused_vs1;
    assign unused_vs1 = ^vs1_i;

    function automatic logic [7:0] sh8(input logic [7:0] a, input logic [2:0] s, input shift_op_e op);
        case (op)
            SLL:     sh8 = a << s;
            SRL:     sh8 = a >> s;
            SRA:     sh8 = $unsigned($signed(a) >>> s);
            default: sh8 = a;
        endcase
    endfunction

    function automatic logic [15:0] sh16(input logic [15:0] a, input logic [3:0] s, input shift_op_e op);
        case (op)
            SLL:     sh16 = a << s;
            SRL:     sh16 = a >> s;
            SRA:     sh16 = $unsigned($signed(a) >>> s);
            default: sh16 = a;
        endcase
    endfunction

    function automatic logic [31:0] sh32(input logic [31:0] a, input logic [4:0] s, input shift_op_e op);
        case (op)
            SLL:     sh32 = a << s;
            SRL:     sh32 = a >> s;
            SRA:     sh32 = $unsigned($signed(a) >>> s);
            default: sh32 = a;
        endcase
    endfunction

    // Per-element shift; amount comes from the broadcast scalar or the matching vs1 element.
    always_comb begin
        res_o = '0;
        case (sew_i)
            SEW8: begin
                for (int unsigned i = 0; i < LANE_W / 8; i++) begin
                    res_o[i*8 +: 8] = sh8(vs2_i[i*8 +: 8],
                                          use_scalar_i ? rs1_i[2:0] : vs1_i[i*8 +: 3], op_i);
                end
            end
            SEW16: begin
                for (int unsigned i = 0; i < LANE_W / 16; i++) begin
                    res_o[i*16 +: 16] = sh16(vs2_i[i*16 +: 16],
                                             use_scalar_i ? rs1_i[3:0] : vs1_i[i*16 +: 4], op_i);
                end
            end
            SEW32: begin
                for (int unsigned i = 0; i < LANE_W / 32; i++) begin
                    res_o[i*32 +: 32] = sh32(vs2_i[i*32 +: 32],
                                             use_scalar_i ? rs1_i : vs1_i[i*32 +: 5], op_i);
                end
            end
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/vector_shift_seq.sv
// Vector shift sequencer: latches one instruction, computes one 128-bit lane per
// cycle with tail-undisturbed merge, then holds the result for writeback.
module vector_shift_seq
    import vector_shift_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [VLEN-1:0] vs2_i,
    input  logic [VLEN-1:0] vs1_i,
    input  logic [VLEN-1:0] vd_old_i,
    input  logic [31:0]     rs1_i,
    input  logic            use_scalar_i,
    input  logic [1:0]      shift_op_i,
    input  logic [1:0]      sew_i,
    input  logic [VL_W-1:0] vl_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [VLEN-1:0] vd_o,
    output logic            err_o,
    output logic            busy_o
);

    seq_state_e      state_q, state_d;
    logic [2:0]      lane_cnt_q, lane_cnt_d;
    logic [VLEN-1:0] vs2_q, vs2_d;
    logic [VLEN-1:0] vs1_q, vs1_d;
    logic [VLEN-1:0] res_q, res_d;
    logic [4:0]      rs1_q, rs1_d;
    logic            use_scalar_q, use_scalar_d;
    shift_op_e       op_q, op_d;
    sew_e            sew_q, sew_d;
    logic [6:0]      active_bytes_q, active_bytes_d;
    logic [2:0]      active_lanes_q, active_lanes_d;
    logic            err_q, err_d;

    // Upper scalar bits never affect a shift amount.
    logic unused_rs1;
    assign unused_rs1 = ^rs1_i[31:5];

    logic            in_err;
    logic [6:0]      vlmax;
    logic [6:0]      vl_eff;
    logic [6:0]      in_bytes;
    logic [2:0]      in_lanes;
    shift_op_e       in_op;
    sew_e            in_sew;

    // Decode the offered instruction: legality, clamped vl, active bytes and lanes.
    always_comb begin
        in_err = (sew_i == 2'b11) || (shift_op_i == 2'b11);
        case (sew_i)
            2'b00:   vlmax = 7'(VLEN / 8);
            2'b01:   vlmax = 7'(VLEN / 16);
            default: vlmax = 7'(VLEN / 32);
        endcase
        vl_eff = (vl_i < VL_W'(vlmax)) ? vl_i[6:0] : vlmax;
        case (sew_i)
            2'b00:   in_bytes = vl_eff;
            2'b01:   in_bytes = {vl_eff[5:0], 1'b0};
            default: in_bytes = {vl_eff[4:0], 2'b00};
        endcase
        in_lanes = 3'((in_bytes + 7'd15) >> 4);
        case (shift_op_i)
            2'b01:   in_op = SRL;
            2'b10:   in_op = SRA;
            default: in_op = SLL;
        endcase
        case (sew_i)
            2'b01:   in_sew = SEW16;
            2'b10:   in_sew = SEW32;
            default: in_sew = SEW8;
        endcase
    end

    logic [1:0]        lane_idx;
    logic [LANE_W-1:0] lane_res;
    logic [LANE_W-1:0] lane_old;
    logic [LANE_W-1:0] lane_merged;

    assign lane_idx = lane_cnt_q[1:0];

    vector_shift_lane_dp u_lane_dp (
        .vs2_i        (vs2_q[lane_idx*LANE_W +: LANE_W]),
        .vs1_i        (vs1_q[lane_idx*LANE_W +: LANE_W]),
        .rs1_i        (rs1_q),
        .use_scalar_i (use_scalar_q),
        .op_i         (op_q),
        .sew_i        (sew_q),
        .res_o        (lane_res)
    );

    // Byte-granular tail merge of the current lane against the preloaded old destination.
    always_comb begin
        lane_old    = res_q[lane_idx*LANE_W +: LANE_W];
        lane_merged = lane_old;
        for (int unsigned j = 0; j < LANE_W / 8; j++) begin
            if ((32'(lane_idx) * 32'(LANE_W / 8) + j) < 32'(active_bytes_q)) begin
                lane_merged[j*8 +: 8] = lane_res[j*8 +: 8];
            end
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d        = state_q;
        lane_cnt_d     = lane_cnt_q;
        vs2_d          = vs2_q;
        vs1_d          = vs1_q;
        res_d          = res_q;
        rs1_d          = rs1_q;
        use_scalar_d   = use_scalar_q;
        op_d           = op_q;
        sew_d          = sew_q;
        active_bytes_d = active_bytes_q;
        active_lanes_d = active_lanes_q;
        err_d          = err_q;
        case (state_q)
            IDLE: begin
                if (issue_valid_i) begin
                    vs2_d          = vs2_i;
                    vs1_d          = vs1_i;
                    res_d          = vd_old_i;
                    rs1_d          = rs1_i[4:0];
                    use_scalar_d   = use_scalar_i;
                    op_d           = in_op;
                    sew_d          = in_sew;
                    err_d          = in_err;
                    active_bytes_d = in_err ? 7'd0 : in_bytes;
                    active_lanes_d = in_err ? 3'd0 : in_lanes;
                    lane_cnt_d     = '0;
                    state_d        = (in_err || (in_lanes == 3'd0)) ? DONE : RUN;
                end
            end
            RUN: begin
                res_d[lane_idx*LANE_W +: LANE_W] = lane_merged;
                lane_cnt_d = lane_cnt_q + 3'd1;
                if (lane_cnt_q == active_lanes_q - 3'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            lane_cnt_q     <= '0;
            vs2_q          <= '0;
            vs1_q          <= '0;
            res_q          <= '0;
            rs1_q          <= '0;
            use_scalar_q   <= 1'b0;
            op_q           <= SLL;
            sew_q          <= SEW8;
            active_bytes_q <= '0;
            active_lanes_q <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            lane_cnt_q     <= lane_cnt_d;
            vs2_q          <= vs2_d;
            vs1_q          <= vs1_d;
            res_q          <= res_d;
            rs1_q          <= rs1_d;
            use_scalar_q   <= use_scalar_d;
            op_q           <= op_d;
            sew_q          <= sew_d;
            active_bytes_q <= active_bytes_d;
            active_lanes_q <= active_lanes_d;
            err_q          <= err_d;
        end
    end

    assign issue_ready_o  = (state_q == IDLE);
    assign result_valid_o = (state_q == DONE);
    assign busy_o         = (state_q != IDLE);
    assign vd_o           = res_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_vector_shift_seq.sv
// Self-checking bench for vector_shift_seq: element-level model plus directed literals.
module tb_vector_shift_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         issue_valid;
    logic         issue_ready_o;
    logic [511:0] vs2, vs1, vd_old;
    logic [31:0]  rs1;
    logic         use_scalar;
    logic [1:0]   op, sew;
    logic [9:0]   vl;
    logic         result_valid_o;
    logic         result_ready;
    logic [511:0] vd_o;
    logic         err_o;
    logic         busy_o;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    vector_shift_seq dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid_i  (issue_valid),
        .issue_ready_o  (issue_ready_o),
        .vs2_i          (vs2),
        .vs1_i          (vs1),
        .vd_old_i       (vd_old),
        .rs1_i          (rs1),
        .use_scalar_i   (use_scalar),
        .shift_op_i     (op),
        .sew_i          (sew),
        .vl_i           (vl),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready),
        .vd_o           (vd_o),
        .err_o          (err_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: per-element arithmetic over the whole register, VLMAX clamp, tail kept.
    function automatic void model(input logic [511:0] a2, input logic [511:0] a1,
                                  input logic [511:0] ao, input logic [31:0] r,
                                  input logic us, input logic [1:0] o, input logic [1:0] s,
                                  input logic [9:0] l, output logic [511:0] res,
                                  output logic err, output int lanes);
        int w, n, ve;
        longint unsigned mask, a, amt, val;
        res   = ao;
        err   = (s == 2'd3) || (o == 2'd3);
        lanes = 0;
        if (err) return;
        w  = 8 << s;
        n  = 512 / w;
        ve = (int'(l) < n) ? int'(l) : n;
        lanes = (ve * w + 127) / 128;
        mask = (64'd1 << w) - 64'd1;
        for (int e = 0; e < ve; e++) begin
            a   = 64'(a2 >> (e * w)) & mask;
            amt = us ? 64'(r) : (64'(a1 >> (e * w)) & mask);
            amt = amt % longint'(w);
            if (o == 2'd0)      val = (a << amt) & mask;
            else if (o == 2'd1) val = a >> amt;
            else                val = (a >> amt) | ((a >> (w - 1)) != 0 ? (mask & ~(mask >> amt)) : 64'd0);
            res = (res & ~(512'(mask) << (e * w))) | (512'(val) << (e * w));
        end
    endfunction

    // Transaction-level expectation of the externally visible handshake state.
    logic [511:0] m_vd, p_vd;
    logic         m_busy, m_valid, m_err, p_err;
    int           m_cnt, m_lanes;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_valid = 0; m_err = 0; m_vd = '0; m_cnt = 0;
        end else if (!m_busy) begin
            if (issue_valid) begin
                model(vs2, vs1, vd_old, rs1, use_scalar, op, sew, vl, p_vd, p_err, m_lanes);
                m_busy = 1;
                if (p_err || m_lanes == 0) begin
                    m_valid = 1; m_vd = p_vd; m_err = p_err;
                end else begin
                    m_cnt = m_lanes;
                end
            end
        end else if (!m_valid) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_valid = 1; m_vd = p_vd; m_err = p_err;
            end
        end else if (result_ready) begin
            m_valid = 0; m_busy = 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking && !reset) begin
            chk("cyc_issue_ready", issue_ready_o, !m_busy);
            chk("cyc_busy", busy_o, m_busy);
            chk("cyc_valid", result_valid_o, m_valid);
            if (m_valid) begin
                chk("cyc_vd", vd_o, m_vd);
                chk("cyc_err", err_o, m_err);
            end
        end
    end

    task automatic run_op(input string nm, input logic [511:0] a2, input logic [511:0] a1,
                          input logic [511:0] ao, input logic [31:0] r, input logic us,
                          input logic [1:0] o, input logic [1:0] s, input logic [9:0] l,
                          input int exp_lat, input bit lit, input logic [511:0] exp_vd,
                          input logic exp_err, input int stall);
        int extra;
        logic [511:0] held;
        @(negedge clk);
        vs2 = a2; vs1 = a1; vd_old = ao; rs1 = r; use_scalar = us; op = o; sew = s; vl = l;
        issue_valid = 1'b1;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        vs2 = ~a2; vs1 = ~a1; vd_old = ~ao; rs1 = ~r; vl = ~l;
        extra = 0;
        while (!result_valid_o && extra < 20) begin
            @(posedge clk); #1;
            extra++;
        end
        chk({nm, "_latency"}, 512'(extra), 512'(exp_lat));
        chk({nm, "_err"}, err_o, exp_err);
        if (lit) chk({nm, "_vd"}, vd_o, exp_vd);
        held = vd_o;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({nm, "_stall_valid"}, result_valid_o, 1'b1);
            chk({nm, "_stall_vd"}, vd_o, held);
            chk({nm, "_stall_issue_ready"}, issue_ready_o, 1'b0);
        end
        @(negedge clk);
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk({nm, "_valid_drop"}, result_valid_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] old, exp;
        reset = 1'b1; issue_valid = 0; result_ready = 0;
        vs2 = '0; vs1 = '0; vd_old = '0; rs1 = '0; use_scalar = 0; op = 0; sew = 0; vl = 0;
        repeat (2) @(negedge clk);
        chk("rst_issue_ready", issue_ready_o, 1'b1);
        chk("rst_valid", result_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_vd", vd_o, 512'd0);
        reset = 1'b0;
        checking = 1'b1;

        old = rand512();
        run_op("sll32_vx", {16{32'h0000_0001}}, rand512(), old, 32'h24, 1, 2'b00, 2'b10, 10'd16,
               4, 1, {16{32'h0000_0010}}, 1'b0, 0);
        run_op("sra8_vv", {64{8'h80}}, {64{8'h0B}}, {64{8'hAA}}, 32'h0, 0, 2'b10, 2'b00, 10'd20,
               2, 1, {{44{8'hAA}}, {20{8'hF0}}}, 1'b0, 0);
        run_op("srl16_clamp", {32{16'h8000}}, rand512(), rand512(), 32'd15, 1, 2'b01, 2'b01, 10'd100,
               4, 1, {32{16'h0001}}, 1'b0, 0);
        old = rand512();
        run_op("vl0_stall", rand512(), rand512(), old, 32'd3, 1, 2'b00, 2'b00, 10'd0,
               0, 1, old, 1'b0, 5);
        old = rand512();
        run_op("bad_sew", rand512(), rand512(), old, 32'd1, 1, 2'b00, 2'b11, 10'd8,
               0, 1, old, 1'b1, 0);
        old = rand512();
        run_op("bad_op", rand512(), rand512(), old, 32'd1, 0, 2'b11, 2'b00, 10'd10,
               0, 1, old, 1'b1, 0);
        run_op("sra16_msb", {32{16'h8000}}, rand512(), rand512(), 32'd4, 1, 2'b10, 2'b01, 10'd32,
               4, 1, {32{16'hF800}}, 1'b0, 0);

        // Reset during the second RUN cycle discards the instruction.
        @(negedge clk);
        vs2 = rand512(); vs1 = rand512(); vd_old = rand512(); rs1 = 32'd2; use_scalar = 1;
        op = 2'b00; sew = 2'b10; vl = 10'd16; issue_valid = 1'b1;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrun_rst_valid", result_valid_o, 1'b0);
        chk("midrun_rst_issue_ready", issue_ready_o, 1'b1);
        chk("midrun_rst_busy", busy_o, 1'b0);
        chk("midrun_rst_vd", vd_o, 512'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_valid", result_valid_o, 1'b0);
            chk("post_rst_issue_ready", issue_ready_o, 1'b1);
        end

        exp = 'x;
        run_op("sll16_vv", rand512(), rand512(), rand512(), 32'd0, 0, 2'b00, 2'b01, 10'd9,
               2, 0, exp, 1'b0, 0);
        run_op("sra32_vv", rand512(), rand512(), rand512(), 32'd0, 0, 2'b10, 2'b10, 10'd7,
               2, 0, exp, 1'b0, 0);
        run_op("srl8_vv", rand512(), rand512(), rand512(), 32'd0, 0, 2'b01, 2'b00, 10'd64,
               4, 0, exp, 1'b0, 0);
        run_op("sll32_vv", rand512(), rand512(), rand512(), 32'd0, 0, 2'b00, 2'b10, 10'd5,
               2, 0, exp, 1'b0, 0);
        run_op("sra8_vx", rand512(), rand512(), rand512(), 32'hFFFF_FFF5, 1, 2'b10, 2'b00, 10'd37,
               3, 0, exp, 1'b0, 0);

        repeat (2) @(negedge clk);
        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vector_shift_seq.md
Name: vector_shift_seq

Overview:
- Multi-cycle sequencer for the vector shift datapath (vsll/vsrl/vsra, vv/vx/vi).
- Accepts one shift instruction through a valid/ready issue port and time-multiplexes a single 128-bit lane datapath across the 512-bit register, one lane per cycle.
- Applies vl-based tail-undisturbed merging against the old destination value.
- Returns the full result through a valid/ready writeback port. Sits between the vector issue stage and the register-file writeback.

Parameters:
- VLEN, 512, vector register width in bits (= `MAX_VLEN).
- LANE_W, 128, datapath lane width in bits.
- NUM_LANES, VLEN/LANE_W (4), lanes per register.
- VL_W, 10, width of the vl input.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- issue_valid_i  in  1  instruction offered.
- issue_ready_o  out  1  sequencer can accept an instruction.
- vs2_i  in  VLEN  source vector (shifted operand).
- vs1_i  in  VLEN  per-element shift amounts (vv form).
- vd_old_i  in  VLEN  previous destination, used for tail elements.
- rs1_i  in  32  scalar or immediate shift amount (vx/vi form).
- use_scalar_i  in  1  1 = vx/vi, 0 = vv.
- shift_op_i  in  2  00 = vsll, 01 = vsrl, 10 = vsra, 11 = illegal.
- sew_i  in  2  00 = 8, 01 = 16, 10 = 32, 11 = illegal.
- vl_i  in  VL_W  active element count.
- result_valid_o  out  1  vd_o/err_o valid.
- result_ready_i  in  1  writeback accepts the result.
- vd_o  out  VLEN  merged result.
- err_o  out  1  illegal sew/op; qualified by result_valid_o.
- busy_o  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous): state = IDLE; issue_ready_o = 1; result_valid_o = 0; busy_o = 0; err_o = 0; vd_o = 0; lane counter = 0.
- All operands, including vd_old_i, are latched on the issue handshake (issue_valid_i && issue_ready_o). Inputs are don't-care afterwards.
- issue_ready_o = 1 only in IDLE; there is no back-to-back overlap.
- FSM states:
  - IDLE: on handshake, go to RUN. Go to DONE instead if err or active_lanes == 0.
  - RUN: each edge writes one lane of the result register and increments lane_cnt. After the edge that writes lane active_lanes-1, go to DONE.
  - DONE: result_valid_o = 1 and is held stable until result_ready_i. On handshake, go to IDLE; result_valid_o drops on that edge.
- vl clamping: vl_eff = min(vl_i, VLEN/SEW). VLMAX is 64, 32 or 16 elements for SEW 8, 16, 32.
- active_bytes = vl_eff*SEW/8.
- active_lanes = ceil(active_bytes/16), range 0..4.
- Result register is preloaded with vd_old on accept. Lanes >= active_lanes are never computed and keep vd_old.
- Within a computed lane, byte b (global index) takes the shift result if b < active_bytes; otherwise it keeps vd_old (tail-undisturbed).
- Latency: result_valid_o is high after exactly active_lanes edges following the accept edge. For vl_eff = 0 or an error, it is high on the cycle immediately after the accept edge.
- Shift semantics per element of width SEW:
  - Shift amount = low log2(SEW) bits of the source (vs1 element or rs1_i).
  - vsll: logical left shift; vsrl: zero-fill right shift.
  - vsra: fills with the element's own MSB at SEW width (not bit 31).
  - vx/vi: rs1_i is broadcast to every element.
- Illegal sew or op: no lanes computed; vd_o = vd_old; err_o = 1.
- Stall: result_ready_i low in DONE holds vd_o and err_o unchanged indefinitely.
- Reset mid-RUN or mid-DONE: instruction discarded, no result produced, all outputs return to reset values immediately.

Decomposition:
- Shared package vector_shift_pkg:
  - typedefs: shift_op_e (SLL, SRL, SRA), sew_e (SEW8, SEW16, SEW32), seq_state_e (IDLE, RUN, DONE).
  - constants: VLEN, LANE_W, NUM_LANES.
- Sub-module vector_shift_lane_dp: combinational 128-bit lane datapath.
  - Inputs: vs2/vs1 lane slices, rs1, use_scalar, op, sew. Output: 128-bit lane result.
  - Instantiated once and muxed by lane_cnt.
- Byte-enable generation and merge stay in the top module.

Test Plan:
- SEW=32, vsll vx, rs1 = 0x24 (amount 4), vs2 elements all 0x0000_0001, vl = 16 -> all 16 elements 0x0000_0010; result_valid 4 edges after accept; err_o = 0.
- SEW=8, vsra vv, vs2 bytes 0x80, vs1 bytes 0x0B (amount 3), vl = 20, vd_old bytes 0xAA -> bytes 0..19 = 0xF0, bytes 20..63 = 0xAA; 2 lanes computed, valid after 2 edges.
- SEW=16, vsrl, vs2 halfwords 0x8000, amount 15, vl = 100 (clamped to 32) -> all halfwords 0x0001; 4 lanes computed.
- vl = 0, any op -> vd_o = vd_old; valid on the cycle after accept; then result_ready_i held low 5 cycles -> vd_o and result_valid_o stable; issue_ready_o = 0 throughout.
- sew_i = 11 -> err_o = 1, vd_o = vd_old, valid after one edge.
- reset asserted during the 2nd RUN cycle -> result_valid_o stays 0; issue_ready_o = 1 on the next cycle; a following legal instruction completes correctly.
